hop_chain_array: RTL

Parametrised multi-channel register-hop pipeline for the hop/level micro-benchmarks. It carries NCH independent channels, each DEPTH stages deep and W bits wide. It adds over the fixed hop designs:
- per-stage valid tracking;
- per-channel synchronous clear;
- a global shift enable;
- per-channel occupancy counters;
- a flush state machine that drains every chain with zeros.

It sits between the benchmark stimulus flops and the observation outputs.

---
 rtl/hop_chain_array.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hop_chain_array.sv
// hop_chain_array
//
// Multi-channel register-hop pipeline. NCH independent channels, each DEPTH
// stages deep and W bits wide. Every stage carries a data word and a valid
// bit. Channels share a shift enable and a flush engine that drains every
// chain with zeros. Each channel also has a synchronous clear and an
// occupancy counter.
//
// Optional feature, macro HOP_CHAIN_PARITY_EN:
//   Each stage also carries an even-parity bit computed from start.
//   The extra output par_err flags a parity mismatch on a valid output word.
//
// Ports:
//   clock0    in   1        clock, rising edge
//   rst1      in   1        asynchronous active-high reset
//   en        in   1        shift enable (all channels advance one stage)
//   start     in   NCH*W    per-channel input data, channel c = start[c*W +: W]
//   in_valid  in   NCH      per-channel input valid
//   clr       in   NCH      per-channel synchronous clear
//   flush     in   1        single-cycle flush request
//   busy      out  1        high while the flush is draining
//   out_data  out  NCH*W    last-stage data per channel
//   out_valid out  NCH      last-stage valid per channel
//   fill      out  NCH*CW   valid-stage count per channel, 0..DEPTH
//   par_err   out  NCH      (HOP_CHAIN_PARITY_EN only) parity mismatch flag
module hop_chain_array #(
    parameter  int NCH   = 4,
    parameter  int DEPTH = 3,
    parameter  int W     = 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clock0,
    input  logic              rst1,
    input  logic              en,
    input  logic [NCH*W-1:0]  start,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH-1:0]    clr,
    input  logic              flush,
    output logic              busy,
    output logic [NCH*W-1:0]  out_data,
    output logic [NCH-1:0]    out_valid,
`ifdef HOP_CHAIN_PARITY_EN
    output logic [NCH*CW-1:0] fill,
    output logic [NCH-1:0]    par_err
`else
    output logic [NCH*CW-1:0] fill
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          shift_en;   // all channels advance on this edge
    logic          drain;      // inject zeros instead of start/in_valid

    // Flush engine: state register
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Flush engine: next state and shift control.
    // The edge that accepts a flush request does not shift. The following
    // DEPTH edges each shift a zero in, so every stage ends up empty.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_en   = 1'b0;
        drain      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                    cnt_next   = CW'(DEPTH);
                end else if (en) begin
                    shift_en = 1'b1;
                end
            end
            ST_FLUSH: begin
                shift_en = 1'b1;
                drain    = 1'b1;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_reg == ST_FLUSH);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DEPTH-1:0][W-1:0] data_reg;
            logic [DEPTH-1:0]        valid_reg;
            logic [CW-1:0]           fill_reg;
            logic [W-1:0]            in_d;
            logic                    in_v;

            assign in_d = drain ? '0   : start[gi*W +: W];
            assign in_v = drain ? 1'b0 : in_valid[gi];

            always_ff @(posedge clock0 or posedge rst1) begin
                if (rst1) begin
                    data_reg  <= '0;
                    valid_reg <= '0;
                    fill_reg  <= '0;
                end else if (clr[gi]) begin
                    // Clear wins over both a normal shift and a flush drain.
                    data_reg  <= '0;
                    valid_reg <= '0;
                    fill_reg  <= '0;
                end else if (shift_en) begin
                    data_reg  <= {data_reg[DEPTH-2:0], in_d};
                    valid_reg <= {valid_reg[DEPTH-2:0], in_v};
                    // Net change in occupancy is (valid in) - (valid out).
                    // The saturation only guards against an inconsistent state.
                    if (in_v && !valid_reg[DEPTH-1] && (fill_reg != CW'(DEPTH))) begin
                        fill_reg <= fill_reg + CW'(1);
                    end else if (!in_v && valid_reg[DEPTH-1] && (fill_reg != '0)) begin
                        fill_reg <= fill_reg - CW'(1);
                    end
                end
            end

            assign out_data[gi*W +: W] = data_reg[DEPTH-1];
            assign out_valid[gi]       = valid_reg[DEPTH-1];
            assign fill[gi*CW +: CW]   = fill_reg;

`ifdef HOP_CHAIN_PARITY_EN
            logic [DEPTH-1:0] par_reg;
            logic             in_p;
            logic             par_err_reg;

            // Even parity: the stored bit makes the word plus bit have even weight.
            assign in_p = drain ? 1'b0 : (^start[gi*W +: W]);

            always_ff @(posedge clock0 or posedge rst1) begin
                if (rst1) begin
                    par_reg <= '0;
                end else if (clr[gi]) begin
                    par_reg <= '0;
                end else if (shift_en) begin
                    par_reg <= {par_reg[DEPTH-2:0], in_p};
                end
            end

            // Checks the word currently on the outputs. The flag shows one cycle later.
            always_ff @(posedge clock0 or posedge rst1) begin
                if (rst1) begin
                    par_err_reg <= 1'b0;
                end else begin
                    par_err_reg <= valid_reg[DEPTH-1] &&
                                   ((^data_reg[DEPTH-1]) != par_reg[DEPTH-1]);
                end
            end

            assign par_err[gi] = par_err_reg;
`endif
        end
    endgenerate

endmodule
